// File: rtl/nes_cpu_bus.sv
// CPU-side bus decoder for the NES: work RAM, PPU/IO/PRG routing, registered read data.
// Define OAM_DMA_EN to build the $4014 sprite-DMA engine; otherwise $4014 is a no-op.
module nes_cpu_bus #(
  parameter int RAM_AW = 11,
  parameter int PRG_AW = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_dout,
  input  logic              cpu_we,
  output logic [7:0]        cpu_din,
  output logic              cpu_rdy,
  output logic              ppu_cs,
  output logic [2:0]        ppu_reg,
  output logic              ppu_we,
  output logic [7:0]        ppu_wdata,
  input  logic [7:0]        ppu_rdata,
  output logic              io_cs,
  output logic              io_we,
  output logic [4:0]        io_addr,
  input  logic [7:0]        io_rdata,
  output logic [PRG_AW-1:0] prg_addr,
  input  logic [7:0]        prg_rdata,
  output logic [3:0]        dbg_state
);

  logic [7:0]  ram [0:(2**RAM_AW)-1];
  logic        parity;
  logic        core_active, dma_read, dma_write;
  logic        bus_en, bus_we;
  logic [15:0] bus_addr;
  logic        is_ram, is_ppu, is_io, is_dma_reg, is_prg;
  logic [7:0]  rd_data;
  logic        rd_hit;
  logic [7:0]  dma_byte;

  always_ff @(posedge clk) begin
    if (rst) parity <= 1'b0;
    else     parity <= ~parity;
  end

`ifdef OAM_DMA_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } dma_state_t;

  dma_state_t dma_state, dma_next;
  logic [7:0] dma_page, dma_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      dma_state <= S_IDLE;
      dma_page  <= 8'h00;
      dma_idx   <= 8'h00;
      dma_byte  <= 8'h00;
    end else begin
      dma_state <= dma_next;
      if (dma_state == S_IDLE && cpu_we && cpu_addr == 16'h4014) begin
        dma_page <= cpu_dout;
        dma_idx  <= 8'h00;
      end
      if (dma_state == S_READ && rd_hit) dma_byte <= rd_data;
      if (dma_state == S_WRITE) dma_idx <= dma_idx + 8'd1;
    end
  end

  always_comb begin
    dma_next = dma_state;
    case (dma_state)
      S_IDLE:  if (cpu_we && cpu_addr == 16'h4014) dma_next = S_WAIT;
      S_WAIT:  dma_next = parity ? S_ALIGN : S_READ;
      S_ALIGN: dma_next = S_READ;
      S_READ:  dma_next = S_WRITE;
      S_WRITE: dma_next = (dma_idx == 8'hFF) ? S_IDLE : S_READ;
      default: dma_next = S_IDLE;
    endcase
  end

  // cpu_rdy=0 means the core must hold its bus cycle; its inputs are ignored until rdy=1.
  assign cpu_rdy     = (dma_state == S_IDLE);
  assign core_active = (dma_state == S_IDLE) && !rst;
  assign dma_read    = (dma_state == S_READ) && !rst;
  assign dma_write   = (dma_state == S_WRITE) && !rst;
  assign bus_addr    = dma_read ? {dma_page, dma_idx} : cpu_addr;
  assign dbg_state   = {parity, dma_state};
`else
  assign cpu_rdy     = 1'b1;
  assign core_active = !rst;
  assign dma_read    = 1'b0;
  assign dma_write   = 1'b0;
  assign bus_addr    = cpu_addr;
  assign dma_byte    = 8'h00;
  assign dbg_state   = {parity, 3'b000};
`endif

  assign is_ram     = (bus_addr[15:13] == 3'b000);
  assign is_ppu     = (bus_addr[15:13] == 3'b001);
  assign is_dma_reg = (bus_addr == 16'h4014);
  assign is_io      = (bus_addr[15:5] == 11'h200) && !is_dma_reg;
  assign is_prg     = bus_addr[15];

  assign bus_en = core_active || dma_read;
  assign bus_we = core_active && cpu_we;

  always_comb begin
    rd_hit  = 1'b1;
    rd_data = 8'h00;
    if (is_ram)      rd_data = ram[bus_addr[RAM_AW-1:0]];
    else if (is_ppu) rd_data = ppu_rdata;
    else if (is_io)  rd_data = io_rdata;
    else if (is_prg) rd_data = prg_rdata;
    else             rd_hit  = 1'b0;
  end

  assign ppu_cs    = (bus_en && is_ppu) || dma_write;
  assign ppu_we    = (bus_we && is_ppu) || dma_write;
  assign ppu_reg   = dma_write ? 3'd4 : bus_addr[2:0];
  assign ppu_wdata = dma_write ? dma_byte : cpu_dout;
  assign io_cs     = bus_en && is_io;
  assign io_we     = bus_we && is_io;
  assign io_addr   = bus_addr[4:0];
  assign prg_addr  = bus_addr[PRG_AW-1:0];

  always_ff @(posedge clk) begin
    if (bus_we && is_ram) ram[bus_addr[RAM_AW-1:0]] <= cpu_dout;
  end

  // Open-bus latch: only mapped core cycles move it; unmapped space and DMA leave it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_din <= 8'h00;
    end else if (core_active) begin
      if (cpu_we) begin
        if (is_ram || is_ppu || is_io || is_dma_reg || is_prg) cpu_din <= cpu_dout;
      end else if (rd_hit) begin
        cpu_din <= rd_data;
      end
    end
  end

endmodule
